// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential signed divider.
package div_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned ITER_COUNT = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ZERO = 3'd1,
    S_PREP = 3'd2,
    S_ITER = 3'd3,
    S_FIX  = 3'd4
  } div_state_t;

endpackage

// File: rtl/add32.sv
// Ripple-free behavioural adder shared by the multiplier and divider datapaths.
module add32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum_c,
  output logic             cout_c
);

  // Full-width add with carry in/out.
  assign {cout_c, sum_c} = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);

endmodule

// File: rtl/signed_divider.sv
// Sequential signed restoring divider: 2W-bit dividend / W-bit divisor,
// truncating toward zero, one quotient bit per clock.
module signed_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 valid,
  output logic                 busy,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int unsigned CNT_W = $clog2(ITER_COUNT);
  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, (WIDTH-1)'(0)};

  div_state_t           state;
  logic [2*WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]     dvs;
  logic [WIDTH-1:0]     dvs_mag;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     q;
  logic [CNT_W-1:0]     count;
  logic                 qneg;
  logic                 rneg;
  logic                 early_ovf;

  logic [2*WIDTH-1:0]   dvd_abs;
  logic [WIDTH-1:0]     dvs_abs;
  logic                 carry;
  logic [WIDTH-1:0]     rem_sh;
  logic [WIDTH-1:0]     trial;
  logic                 no_borrow;
  logic                 take;
  logic                 q_ovf;

  // Operand magnitudes from the latched operands.
  assign dvd_abs = dvd[2*WIDTH-1] ? (~dvd + (2*WIDTH)'(1)) : dvd;
  assign dvs_abs = dvs[WIDTH-1]   ? (~dvs + WIDTH'(1))     : dvs;

  // Shifted partial remainder; the bit shifted out of rem acts as a 33rd bit.
  assign carry  = rem[WIDTH-1];
  assign rem_sh = {rem[WIDTH-2:0], q[WIDTH-1]};

  // Trial subtraction rem_sh - |divisor| through the shared adder.
  add32 #(.WIDTH(WIDTH)) u_add (
    .a      (rem_sh),
    .b      (~dvs_mag),
    .cin    (1'b1),
    .sum_c  (trial),
    .cout_c (no_borrow)
  );

  assign take = carry | no_borrow;

  // Unsigned quotient magnitude out of range for the signed result.
  assign q_ovf = qneg ? (q > MIN_MAG) : q[WIDTH-1];

  // Control FSM and datapath registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_IDLE;
      dvd         <= '0;
      dvs         <= '0;
      dvs_mag     <= '0;
      rem         <= '0;
      q           <= '0;
      count       <= '0;
      qneg        <= 1'b0;
      rneg        <= 1'b0;
      early_ovf   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            dvd         <= dividend;
            dvs         <= divisor;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            state       <= (divisor == '0) ? S_ZERO : S_PREP;
          end else begin
            busy <= 1'b0;
          end
        end
        S_ZERO: begin
          quotient    <= '1;
          remainder   <= dvd[WIDTH-1:0];
          div_by_zero <= 1'b1;
          valid       <= 1'b1;
          state       <= S_IDLE;
        end
        S_PREP: begin
          qneg    <= dvd[2*WIDTH-1] ^ dvs[WIDTH-1];
          rneg    <= dvd[2*WIDTH-1];
          dvs_mag <= dvs_abs;
          if (dvd_abs[2*WIDTH-1:WIDTH] >= dvs_abs) begin
            early_ovf <= 1'b1;
            state     <= S_FIX;
          end else begin
            early_ovf <= 1'b0;
            rem       <= dvd_abs[2*WIDTH-1:WIDTH];
            q         <= dvd_abs[WIDTH-1:0];
            count     <= '0;
            state     <= S_ITER;
          end
        end
        S_ITER: begin
          rem   <= take ? trial : rem_sh;
          q     <= {q[WIDTH-2:0], take};
          count <= count + CNT_W'(1);
          if (count == CNT_W'(ITER_COUNT - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          valid <= 1'b1;
          state <= S_IDLE;
          if (early_ovf || q_ovf) begin
            overflow  <= 1'b1;
            quotient  <= '0;
            remainder <= '0;
          end else begin
            quotient  <= qneg ? (~q + WIDTH'(1))   : q;
            remainder <= rneg ? (~rem + WIDTH'(1)) : rem;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
